// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for the multicycle MIPS datapath. Sequences fetch, decode,
//   execute, memory and writeback for R-type, LW, SW, BEQ, BNE, ADDI, ORI
//   and J, stalling memory states on the memready handshake.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset, forces FETCH
//   op[5:0]   in   opcode from the instruction register
//   memready  in   memory completes the current access this cycle
//   pcwrite, branch, bne, irwrite, iord, memwrite, regwrite, regdst,
//   memtoreg, alusrca        out  datapath selects / write enables
//   alusrcb[1:0], pcsrc[1:0], aluop[1:0]   out  datapath mux selects
//   illegal   out  one-cycle pulse in DECODE on an unrecognised opcode
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       branch,
  output logic       bne,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IMMWB   = 4'd12,
    S_JEX     = 4'd13
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_pcwrite;
  logic   w_irwrite;
  logic   w_memwrite;
  logic   w_regwrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Outputs are decoded from state (Moore) so that an asynchronous reset
  // takes effect on them immediately; FETCH alone also looks at memready.
  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    w_irwrite  = 1'b0;
    iord       = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = memready;
        w_pcwrite = memready;
        w_next    = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQEX;
          OP_BNE:       w_next = S_BNEEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_ORI:       w_next = S_ORIEX;
          OP_J:         w_next = S_JEX;
          default: begin
            w_next  = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = memready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        w_next  = S_FETCH;
      end
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        bne     = 1'b1;
        w_next  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b00;
        w_next  = S_IMMWB;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        w_next  = S_IMMWB;
      end
      S_IMMWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write strobes are gated by reset so nothing is written while it is held.
  assign pcwrite  = w_pcwrite  & ~reset;
  assign irwrite  = w_irwrite  & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign regwrite = w_regwrite & ~reset;

endmodule
